multi_cycle_comparator: RTL and testbench

//   Parametrised, multi-cycle magnitude comparator; successor to the 8-bit combinational comparator.

---
 rtl/multi_cycle_comparator_if.sv | 23 ++
 rtl/multi_cycle_comparator.sv | 109 ++++++++++
 tb/tb_multi_cycle_comparator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_comparator_if.sv
// Start/done handshake bundle for multi_cycle_comparator.
// The master issues operands and start; the slave (comparator) returns busy, done and flags.
interface multi_cycle_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [7:0]       flags;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, flags
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, flags
    );
endinterface

// File: rtl/multi_cycle_comparator.sv
// MSB-first magnitude comparator, CHUNK bits per clock, producing the XXXXXGEL flag word.
// Define COMP_EARLY_EXIT_EN to finish on the first differing chunk instead of after NCHUNK cycles.
module multi_cycle_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_cycle_comparator_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CW-1:0]    CNT_TOP  = CW'(NCHUNK - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d;
    logic             done_q, done_d;
    logic [2:0]       gel_q, gel_d;

    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic             chunk_gt, chunk_lt;
    logic             decided_now, gt_now, last_step;

    assign chunk_a  = a_q[int'(cnt_q) * CHUNK +: CHUNK];
    assign chunk_b  = b_q[int'(cnt_q) * CHUNK +: CHUNK];
    assign chunk_gt = (chunk_a > chunk_b);
    assign chunk_lt = (chunk_a < chunk_b);

    // Once a higher chunk has decided, lower chunks can no longer change the outcome.
    assign decided_now = decided_q | chunk_gt | chunk_lt;
    assign gt_now      = decided_q ? gt_q : chunk_gt;

`ifdef COMP_EARLY_EXIT_EN
    assign last_step = (cnt_q == '0) | chunk_gt | chunk_lt;
`else
    assign last_step = (cnt_q == '0);
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        done_d    = 1'b0;
        gel_d     = gel_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    // Flipping both MSBs maps two's complement onto offset binary.
                    a_d       = bus.a ^ (MSB_MASK & {WIDTH{bus.signed_mode}});
                    b_d       = bus.b ^ (MSB_MASK & {WIDTH{bus.signed_mode}});
                    cnt_d     = CNT_TOP;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                end
            end
            RUN: begin
                decided_d = decided_now;
                gt_d      = gt_now;
                cnt_d     = cnt_q - 1'b1;
                if (last_step) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    gel_d   = {gt_now, ~decided_now, decided_now & ~gt_now};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            done_q    <= 1'b0;
            gel_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            done_q    <= done_d;
            gel_q     <= gel_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.flags = {5'b00000, gel_q};
endmodule

// File: tb/tb_multi_cycle_comparator.sv
// Scoreboard bench for multi_cycle_comparator: 8/2 instance for most scenarios, 16/4 instance for the wide case.
// Expected flags come from an integer compare model; expected latency from a chunk-scan model.
module tb_multi_cycle_comparator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_cycle_comparator_if #(.WIDTH(8))  bus8 ();
    multi_cycle_comparator_if #(.WIDTH(16)) bus16 ();

    multi_cycle_comparator #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    multi_cycle_comparator #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    typedef struct {
        logic [7:0] flags;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];

    function automatic logic [7:0] exp_flags(logic [15:0] a, logic [15:0] b, bit sm, int w);
        int sa = int'(a);
        int sb_ = int'(b);
        if (sm && a[w-1]) sa = sa - (1 << w);
        if (sm && b[w-1]) sb_ = sb_ - (1 << w);
        if (sa > sb_) return 8'h04;
        if (sa < sb_) return 8'h01;
        return 8'h02;
    endfunction

    function automatic int exp_lat(logic [15:0] a, logic [15:0] b, bit sm, int w, int ch);
`ifdef COMP_EARLY_EXIT_EN
        logic [15:0] mask = 16'((1 << ch) - 1);
        if (sm) begin
            a[w-1] = ~a[w-1];
            b[w-1] = ~b[w-1];
        end
        for (int i = w / ch - 1; i >= 0; i--)
            if (((a >> (i * ch)) & mask) != ((b >> (i * ch)) & mask))
                return w / ch - i;
        return w / ch;
`else
        return w / ch;
`endif
    endfunction

    // Scoreboard: every done must match the oldest outstanding op in flags and arrival cycle.
    always @(negedge clk) begin
        if (!rst && bus8.done === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL spurious_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus8.flags !== e.flags) begin
                    n_err++;
                    $display("FAIL sb_flags: flags=%h required %h", bus8.flags, e.flags);
                end
                n_cmp++;
                if (cyc != e.done_cyc) begin
                    n_err++;
                    $display("FAIL sb_latency: done at cycle %0d required %0d", cyc, e.done_cyc);
                end
            end
        end
    end

    // Drive one start at the current negedge; push an expectation when it will be accepted.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit sm, input bit accept);
        exp_t e;
        bus8.start       = 1'b1;
        bus8.a           = a;
        bus8.b           = b;
        bus8.signed_mode = sm;
        if (accept) begin
            e.flags    = exp_flags({8'h00, a}, {8'h00, b}, sm, 8);
            e.done_cyc = cyc + 1 + exp_lat({8'h00, a}, {8'h00, b}, sm, 8, 2);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int budget = 40;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d ops outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit sm);
        issue(a, b, sm, 1'b1);
        @(negedge clk);
        bus8.start = 1'b0;
        drain();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus8.busy, bus8.done, bus8.flags} !== 10'h000) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b flags=%h required 0 0 00",
                     bus8.busy, bus8.done, bus8.flags);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus8.busy !== 1'b0 || bus8.flags !== 8'h00) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b flags=%h required 0 00", bus8.busy, bus8.flags);
        end
    endtask

    task automatic test_unsigned();
        run_op(8'hA5, 8'h3C, 1'b0);
        run_op(8'h5A, 8'h5A, 1'b0);
        run_op(8'h3C, 8'hA5, 1'b0);
        n_cmp++;
        if (bus8.flags !== 8'h01) begin
            n_err++;
            $display("FAIL flags_hold: flags=%h required 01", bus8.flags);
        end
    endtask

    task automatic test_signed();
        run_op(8'h80, 8'h7F, 1'b1);
        run_op(8'h80, 8'h7F, 1'b0);
        run_op(8'hFF, 8'h01, 1'b1);
        run_op(8'hFE, 8'hFF, 1'b1);
        run_op(8'h7F, 8'h7F, 1'b1);
    endtask

    task automatic test_back_to_back();
        int done1;
        int budget = 20;
        issue(8'h10, 8'h20, 1'b0, 1'b1);
        done1 = sb[$].done_cyc;
        @(negedge clk);
        issue(8'hFF, 8'h00, 1'b1, 1'b0);
        do begin
            @(negedge clk);
            budget--;
            if (cyc != done1) bus8.start = 1'b0;
        end while (cyc != done1 && budget > 0);
        n_cmp++;
        if (bus8.done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done_cycle: done=%b required 1", bus8.done);
        end
        issue(8'h5A, 8'h5A, 1'b0, 1'b1);
        @(negedge clk);
        bus8.start = 1'b0;
        n_cmp++;
        if (bus8.busy !== 1'b1 || bus8.flags !== 8'h01) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b flags=%h required 1 01", bus8.busy, bus8.flags);
        end
        drain();
    endtask

    task automatic test_reset_abort();
        issue(8'h01, 8'h02, 1'b0, 1'b1);
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        n_cmp++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.flags !== 8'h00) begin
            n_err++;
            $display("FAIL reset_abort: busy=%b done=%b flags=%h required 0 0 00",
                     bus8.busy, bus8.done, bus8.flags);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus8.busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_abort_idle: busy=%b required 0", bus8.busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra = 8'($urandom);
            logic [7:0] rb = (i % 3 == 0) ? ra : 8'($urandom);
            run_op(ra, rb, 1'($urandom_range(1)));
        end
    endtask

    task automatic test_wide();
        int c;
        int budget = 20;
        logic [15:0] wa = 16'h1234;
        logic [15:0] wb = 16'h1235;
        bus16.start       = 1'b1;
        bus16.a           = wa;
        bus16.b           = wb;
        bus16.signed_mode = 1'b0;
        c = cyc + 1;
        @(negedge clk);
        bus16.start = 1'b0;
        while (bus16.done !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_cmp++;
        if (bus16.flags !== exp_flags(wa, wb, 1'b0, 16) || bus16.flags !== 8'h01) begin
            n_err++;
            $display("FAIL wide_flags: flags=%h required 01", bus16.flags);
        end
        n_cmp++;
        if (cyc - c != exp_lat(wa, wb, 1'b0, 16, 4) || cyc - c != 4) begin
            n_err++;
            $display("FAIL wide_latency: %0d cycles required 4", cyc - c);
        end
    endtask

    initial begin
        bus8.start        = 1'b0;
        bus8.signed_mode  = 1'b0;
        bus8.a            = '0;
        bus8.b            = '0;
        bus16.start       = 1'b0;
        bus16.signed_mode = 1'b0;
        bus16.a           = '0;
        bus16.b           = '0;
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_wide();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
